keccak_sponge_ctrl: RTL

Sponge sequencer wrapping the 24-round Keccak-f[1600] permutation core for Kyber768 SHAKE128 (XOF, rate 168 B) and SHAKE256 (PRF, rate 136 B).
- Absorbs a 64-bit word stream into the rate portion of a local 1600-bit state and applies FIPS 202 SHAKE padding.
- Launches the permutation core through a start/done handshake.
- Streams squeezed 64-bit lanes out, re-permuting when a rate block is exhausted.

---
 rtl/keccak_sponge_if.sv | 34 +++
 rtl/keccak_sponge_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/keccak_sponge_if.sv
// Stream bundle for the Keccak sponge sequencer:
// message words flow in, squeezed lanes flow out.
interface keccak_sponge_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_last;
    logic [3:0]  in_bytes;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output in_bytes,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  in_bytes,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/keccak_sponge_ctrl.sv
// SHAKE128/SHAKE256 sponge sequencer around an external
// Keccak-f[1600] core: absorb, pad, permute, squeeze.
module keccak_sponge_ctrl #(
    parameter int OUTW_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [OUTW_W-1:0] out_words,
    keccak_sponge_if.slave    io,
    output logic              busy,
    output logic              done,
    output logic              perm_start,
    output logic [1599:0]     perm_state_in,
    input  logic [1599:0]     perm_state_out,
    input  logic              perm_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ABSORB,
        S_PERM,
        S_SQUEEZE
    } fsm_t;

    typedef enum logic [1:0] {
        PH_ABS,
        PH_FINAL,
        PH_SQZ
    } phase_t;

    fsm_t              fsm;
    phase_t            phase;
    logic              pad_pending;
    logic [1599:0]     st;
    logic [4:0]        idx;
    logic [4:0]        rate_lanes;
    logic [OUTW_W-1:0] remaining;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [63:0]       out_data_q;

    logic [4:0]        idx_nx;
    logic [7:0]        rate_bytes;
    logic [7:0]        last_rate_byte;
    logic [7:0]        pad_pos;
    logic [3:0]        nb;
    logic              pad_split;
    logic [63:0]       byte_mask;
    logic [63:0]       in_word;
    logic [63:0]       next_lane;
    logic [1599:0]     absorb_st;
    logic [1599:0]     pad_st;

    assign io.in_ready     = in_ready_q;
    assign io.out_valid    = out_valid_q;
    assign io.out_data     = out_data_q;
    assign perm_state_in   = st;

    assign idx_nx         = idx + 5'd1;
    assign rate_bytes     = {rate_lanes, 3'b000};
    assign last_rate_byte = rate_bytes - 8'd1;
    assign nb             = (io.in_bytes > 4'd8) ? 4'd8 : io.in_bytes;
    assign pad_pos        = {idx, 3'b000} + {4'b0000, nb};
    // A full final block pushes the whole pad into one more block
    assign pad_split      = (pad_pos == rate_bytes);
    assign in_word        = io.in_last ? (io.in_data & byte_mask)
                                       : io.in_data;
    assign next_lane      = st[{idx_nx, 6'b0} +: 64];

    always_comb begin
        byte_mask = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < int'(nb)) begin
                byte_mask[k*8 +: 8] = 8'hFF;
            end
        end
    end

    always_comb begin
        absorb_st = st;
        absorb_st[{idx, 6'b0} +: 64] =
            st[{idx, 6'b0} +: 64] ^ in_word;
        if (io.in_last && !pad_split) begin
            absorb_st[{pad_pos, 3'b000} +: 8] =
                absorb_st[{pad_pos, 3'b000} +: 8] ^ 8'h1F;
            absorb_st[{last_rate_byte, 3'b000} +: 8] =
                absorb_st[{last_rate_byte, 3'b000} +: 8] ^ 8'h80;
        end
    end

    always_comb begin
        pad_st = perm_state_out;
        pad_st[7:0] = perm_state_out[7:0] ^ 8'h1F;
        pad_st[{last_rate_byte, 3'b000} +: 8] =
            perm_state_out[{last_rate_byte, 3'b000} +: 8] ^ 8'h80;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm         <= S_IDLE;
            phase       <= PH_ABS;
            pad_pending <= 1'b0;
            st          <= '0;
            idx         <= '0;
            rate_lanes  <= 5'd21;
            remaining   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            perm_start  <= 1'b0;
        end else begin
            perm_start <= 1'b0;
            done       <= 1'b0;
            unique case (fsm)
                S_IDLE: begin
                    if (start) begin
                        rate_lanes  <= mode ? 5'd17 : 5'd21;
                        remaining   <= out_words;
                        st          <= '0;
                        idx         <= '0;
                        pad_pending <= 1'b0;
                        busy        <= 1'b1;
                        in_ready_q  <= 1'b1;
                        fsm         <= S_ABSORB;
                    end
                end
                S_ABSORB: begin
                    if (io.in_valid) begin
                        st <= absorb_st;
                        if (io.in_last) begin
                            in_ready_q  <= 1'b0;
                            perm_start  <= 1'b1;
                            pad_pending <= pad_split;
                            phase       <= pad_split ? PH_ABS : PH_FINAL;
                            fsm         <= S_PERM;
                        end else begin
                            idx <= idx_nx;
                            if (idx_nx == rate_lanes) begin
                                in_ready_q <= 1'b0;
                                perm_start <= 1'b1;
                                phase      <= PH_ABS;
                                fsm        <= S_PERM;
                            end
                        end
                    end
                end
                S_PERM: begin
                    if (perm_done) begin
                        idx <= '0;
                        if (pad_pending) begin
                            st          <= pad_st;
                            pad_pending <= 1'b0;
                            phase       <= PH_FINAL;
                            perm_start  <= 1'b1;
                        end else if (phase == PH_ABS) begin
                            st         <= perm_state_out;
                            in_ready_q <= 1'b1;
                            fsm        <= S_ABSORB;
                        end else begin
                            st <= perm_state_out;
                            if (remaining == '0) begin
                                done <= 1'b1;
                                busy <= 1'b0;
                                fsm  <= S_IDLE;
                            end else begin
                                out_valid_q <= 1'b1;
                                out_data_q  <= perm_state_out[63:0];
                                fsm         <= S_SQUEEZE;
                            end
                        end
                    end
                end
                S_SQUEEZE: begin
                    if (io.out_ready) begin
                        remaining <= remaining - 1'b1;
                        idx       <= idx_nx;
                        if (remaining == {{(OUTW_W-1){1'b0}}, 1'b1}) begin
                            out_valid_q <= 1'b0;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            fsm         <= S_IDLE;
                        end else if (idx_nx == rate_lanes) begin
                            out_valid_q <= 1'b0;
                            perm_start  <= 1'b1;
                            phase       <= PH_SQZ;
                            fsm         <= S_PERM;
                        end else begin
                            out_data_q <= next_lane;
                        end
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule
